// File: rtl/bus_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_master_arbiter_if
//
// Purpose: bundles everything that passes between the bus arbiter, the DMA
// style bus masters, the S1C88 CPU and the shared system bus.
//
// Signal summary (NUM_MASTERS = number of requesters, 1..4):
//   req            [N]     per-master level request
//   grant          [N]     one-hot registered grant
//   m_address      [24N]   packed master addresses, master i at [24i+23:24i]
//   m_data_out     [8N]    packed master write data
//   m_write/m_read [N]     master strobes
//   m_bus_status   [2N]    packed master bus status
//   cpu_*                  CPU bus outputs (address/data/write/read/status)
//   cpu_bus_request        arbiter asks the CPU to release the bus
//   cpu_bus_ack            CPU has released the bus
//   address_out, data_out, write, read, bus_status   shared bus
//   owner          [2]     index of the granted master, valid while |grant
//   busy                   arbiter is not idle
//
// Modports:
//   slave  - the arbiter side (consumes requests, produces grant and bus)
//   master - the environment side (requesters, CPU and bus observers)
// -----------------------------------------------------------------------------
interface bus_master_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    req;
  logic [NUM_MASTERS-1:0]    grant;
  logic [24*NUM_MASTERS-1:0] m_address;
  logic [8*NUM_MASTERS-1:0]  m_data_out;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [NUM_MASTERS-1:0]    m_read;
  logic [2*NUM_MASTERS-1:0]  m_bus_status;

  logic [23:0]               cpu_address;
  logic [7:0]                cpu_data_out;
  logic                      cpu_write;
  logic                      cpu_read;
  logic [1:0]                cpu_bus_status;
  logic                      cpu_bus_request;
  logic                      cpu_bus_ack;

  logic [23:0]               address_out;
  logic [7:0]                data_out;
  logic                      write;
  logic                      read;
  logic [1:0]                bus_status;

  logic [1:0]                owner;
  logic                      busy;

  modport slave (
    input  req, m_address, m_data_out, m_write, m_read, m_bus_status,
    input  cpu_address, cpu_data_out, cpu_write, cpu_read, cpu_bus_status,
    input  cpu_bus_ack,
    output grant, cpu_bus_request,
    output address_out, data_out, write, read, bus_status,
    output owner, busy
  );

  modport master (
    output req, m_address, m_data_out, m_write, m_read, m_bus_status,
    output cpu_address, cpu_data_out, cpu_write, cpu_read, cpu_bus_status,
    output cpu_bus_ack,
    input  grant, cpu_bus_request,
    input  address_out, data_out, write, read, bus_status,
    input  owner, busy
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// bus_master_arbiter
//
// Purpose: shares the system bus between the S1C88 CPU and up to NUM_MASTERS
// DMA style bus masters. All master requests are collapsed into the CPU's
// single bus_request/bus_ack handshake; once the CPU lets go of the bus one
// master at a time is granted, chosen round-robin. A contended owner is
// preempted after MAX_HOLD cycles, but only between strobes. The granted
// master's address, data, strobes and status are muxed onto the shared bus.
//
// Parameters:
//   NUM_MASTERS  number of requesters, 1..4
//   MAX_HOLD     tenure limit in cycles for a contended owner, 0 = unlimited
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   reset   synchronous, active-high
//   bus     bus_master_arbiter_if.slave (see the interface file)
// -----------------------------------------------------------------------------
module bus_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_master_arbiter_if.slave  bus
);

  localparam int            N          = NUM_MASTERS;
  localparam int            CW         = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  // Starting the pointer on the last master makes master 0 the first winner.
  localparam logic [1:0]    LAST_RESET = 2'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    GRANTED,
    SWITCH,
    RELEASE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          cpu_bus_request_q, cpu_bus_request_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    winner_q, winner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // One-hot decode of a master index.
  function automatic logic [N-1:0] onehot(input logic [1:0] idx);
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++) oh[i] = (2'(i) == idx);
    return oh;
  endfunction

  // Round-robin choice: first set request scanning upward from from+1 with
  // wrap-around. Scanning the distances from far to near lets the nearest
  // requester overwrite any farther one.
  function automatic pick_t pick(input logic [N-1:0] r, input logic [1:0] from);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(from) + k) % N;
      if (|(r & onehot(2'(idx)))) res = '{valid: 1'b1, idx: 2'(idx)};
    end
    return res;
  endfunction

  pick_t sel;
  logic  req_owner;
  logic  req_winner;
  logic  req_others;
  logic  owner_strobe;
  logic  preempt;

  assign sel          = pick(bus.req, last_q);
  assign req_owner    = |(bus.req & onehot(owner_q));
  assign req_winner   = |(bus.req & onehot(winner_q));
  assign req_others   = |(bus.req & ~onehot(owner_q));
  assign owner_strobe = |((bus.m_read | bus.m_write) & onehot(owner_q));

  // Preemption only between strobes so an owner never loses the bus in the
  // middle of an access.
  assign preempt = (MAX_HOLD != 0) && (cnt_q == HOLD_LIMIT) && req_others
                   && !owner_strobe;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       grant_now;
  logic [1:0] grant_idx;

  always_comb begin
    // NOTE: every variable gets a default before the case so that paths which
    // do not assign it hold their value instead of inferring a latch.
    state_d           = state_q;
    grant_d           = grant_q;
    cpu_bus_request_d = cpu_bus_request_q;
    owner_d           = owner_q;
    winner_d          = winner_q;
    last_d            = last_q;
    cnt_d             = cnt_q;
    grant_now         = 1'b0;
    grant_idx         = '0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          winner_d          = sel.idx;
          cpu_bus_request_d = 1'b1;
          state_d           = REQUEST;
        end
      end

      REQUEST: begin
        if (bus.cpu_bus_ack) begin
          if (req_winner) begin
            grant_now = 1'b1;
            grant_idx = winner_q;
          end else if (sel.valid) begin
            // The latched winner gave up while waiting; hand the bus to the
            // next requester instead of bouncing the CPU.
            grant_now = 1'b1;
            grant_idx = sel.idx;
          end else begin
            cpu_bus_request_d = 1'b0;
            state_d           = RELEASE;
          end
        end
      end

      GRANTED: begin
        if (cnt_q != HOLD_LIMIT) cnt_d = cnt_q + 1'b1;
        if (!req_owner) begin
          grant_d = '0;
          if (req_others) begin
            state_d = SWITCH;
          end else begin
            cpu_bus_request_d = 1'b0;
            state_d           = RELEASE;
          end
        end else if (preempt) begin
          grant_d = '0;
          state_d = SWITCH;
        end
      end

      // One bus-idle cycle between owners; the CPU stays off the bus.
      SWITCH: begin
        if (sel.valid) begin
          grant_now = 1'b1;
          grant_idx = sel.idx;
        end else begin
          cpu_bus_request_d = 1'b0;
          state_d           = RELEASE;
        end
      end

      // Wait for the CPU to take the bus back; requests wait until IDLE.
      RELEASE: begin
        cpu_bus_request_d = 1'b0;
        if (!bus.cpu_bus_ack) state_d = IDLE;
      end

      default: begin
        grant_d           = '0;
        cpu_bus_request_d = 1'b0;
        state_d           = IDLE;
      end
    endcase

    if (grant_now) begin
      grant_d = onehot(grant_idx);
      owner_d = grant_idx;
      last_d  = grant_idx;
      cnt_d   = '0;
      state_d = GRANTED;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      grant_q           <= '0;
      cpu_bus_request_q <= 1'b0;
      owner_q           <= '0;
      winner_q          <= '0;
      last_q            <= LAST_RESET;
      cnt_q             <= '0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      cpu_bus_request_q <= cpu_bus_request_d;
      owner_q           <= owner_d;
      winner_q          <= winner_d;
      last_q            <= last_d;
      cnt_q             <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared bus mux
  // ---------------------------------------------------------------------------
  logic [23:0] own_address;
  logic [7:0]  own_data;
  logic        own_write;
  logic        own_read;
  logic [1:0]  own_status;

  always_comb begin
    own_address = '0;
    own_data    = '0;
    own_write   = 1'b0;
    own_read    = 1'b0;
    own_status  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == 2'(i)) begin
        own_address = bus.m_address[24*i +: 24];
        own_data    = bus.m_data_out[8*i +: 8];
        own_write   = bus.m_write[i];
        own_read    = bus.m_read[i];
        own_status  = bus.m_bus_status[2*i +: 2];
      end
    end
  end

  logic [23:0] mux_address;
  logic [7:0]  mux_data;
  logic        mux_write;
  logic        mux_read;
  logic [1:0]  mux_status;

  // Outside a tenure the bus is driven idle whenever the CPU has let go of
  // it, so neither side drives a stray access during hand-over.
  always_comb begin
    if (state_q == GRANTED) begin
      mux_address = own_address;
      mux_data    = own_data;
      mux_write   = own_write;
      mux_read    = own_read;
      mux_status  = own_status;
    end else if (bus.cpu_bus_ack) begin
      mux_address = '0;
      mux_data    = '0;
      mux_write   = 1'b0;
      mux_read    = 1'b0;
      mux_status  = 2'b00;
    end else begin
      mux_address = bus.cpu_address;
      mux_data    = bus.cpu_data_out;
      mux_write   = bus.cpu_write;
      mux_read    = bus.cpu_read;
      mux_status  = bus.cpu_bus_status;
    end
  end

  assign bus.address_out     = mux_address;
  assign bus.data_out        = mux_data;
  assign bus.write           = mux_write;
  assign bus.read            = mux_read;
  assign bus.bus_status      = mux_status;
  assign bus.grant           = grant_q;
  assign bus.cpu_bus_request = cpu_bus_request_q;
  assign bus.owner           = owner_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_master_arbiter
//
// Self-checking bench for bus_master_arbiter with two masters and a tenure
// limit of 8. Directed scenarios compare against fixed expectations; the
// random scenario compares every cycle against a transaction-level model of
// the arbitration rules kept in this file.
// -----------------------------------------------------------------------------
module tb_bus_master_arbiter;

  localparam int             N     = 2;
  localparam int             HOLD  = 8;
  localparam logic [N-1:0]   ONE_N = {{(N-1){1'b0}}, 1'b1};

  // Model phases.
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_OWNED = 2;
  localparam int M_GAP   = 3;
  localparam int M_REL   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_master_arbiter_if #(.NUM_MASTERS(N)) bus ();

  bus_master_arbiter #(
    .NUM_MASTERS(N),
    .MAX_HOLD   (HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state.
  int md_phase     = M_IDLE;
  int md_owner     = -1;
  int md_last      = N - 1;
  int md_pending   = 0;
  int md_tenure    = 0;
  int md_owner_out = 0;
  bit md_cpu_req   = 1'b0;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Next requester after 'from', wrapping around; -1 when nobody requests.
  function automatic int rr_next(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(r, (from + k) % N)) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (md_owner >= 0) g = ONE_N << md_owner;
    return g;
  endfunction

  // {address, data, write, read, status} of master o as currently driven.
  function automatic logic [35:0] master_bus(input int o);
    logic [24*N-1:0] a;
    logic [8*N-1:0]  d;
    logic [2*N-1:0]  s;
    a = bus.m_address >> (24 * o);
    d = bus.m_data_out >> (8 * o);
    s = bus.m_bus_status >> (2 * o);
    return {a[23:0], d[7:0], bit_of(bus.m_write, o), bit_of(bus.m_read, o), s[1:0]};
  endfunction

  function automatic logic [35:0] exp_bus();
    if (md_phase == M_OWNED) return master_bus(md_owner);
    if (bus.cpu_bus_ack) return 36'h0;
    return {bus.cpu_address, bus.cpu_data_out, bus.cpu_write, bus.cpu_read, bus.cpu_bus_status};
  endfunction

  // Apply the arbitration rules for one clock edge using the current inputs.
  task automatic model_edge();
    logic [N-1:0] rq;
    int           w;
    bit           others;
    rq = bus.req;
    w  = -1;
    if (reset) begin
      md_phase     = M_IDLE;
      md_owner     = -1;
      md_last      = N - 1;
      md_pending   = 0;
      md_tenure    = 0;
      md_owner_out = 0;
      md_cpu_req   = 1'b0;
      return;
    end
    case (md_phase)
      M_IDLE: begin
        if (rq != '0) begin
          md_pending = rr_next(rq, md_last);
          md_cpu_req = 1'b1;
          md_phase   = M_REQ;
        end
      end
      M_REQ: begin
        if (bus.cpu_bus_ack) begin
          w = bit_of(rq, md_pending) ? md_pending : rr_next(rq, md_last);
          if (w < 0) begin
            md_cpu_req = 1'b0;
            md_phase   = M_REL;
          end
        end
      end
      M_OWNED: begin
        others = (rq & ~(ONE_N << md_owner)) != '0;
        if (!bit_of(rq, md_owner)) begin
          md_owner = -1;
          if (others) md_phase = M_GAP;
          else begin
            md_cpu_req = 1'b0;
            md_phase   = M_REL;
          end
        end else if (md_tenure >= HOLD && others &&
                     !bit_of(bus.m_read, md_owner) && !bit_of(bus.m_write, md_owner)) begin
          md_owner = -1;
          md_phase = M_GAP;
        end else begin
          md_tenure++;
        end
      end
      M_GAP: begin
        w = rr_next(rq, md_last);
        if (w < 0) begin
          md_cpu_req = 1'b0;
          md_phase   = M_REL;
        end
      end
      M_REL: begin
        if (!bus.cpu_bus_ack) md_phase = M_IDLE;
      end
      default: md_phase = M_IDLE;
    endcase
    if (w >= 0) begin
      md_owner     = w;
      md_last      = w;
      md_owner_out = w;
      md_tenure    = 0;
      md_phase     = M_OWNED;
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.req         = '0;
    bus.m_read      = '0;
    bus.m_write     = '0;
    bus.cpu_bus_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset              = 1'b1;
    bus.req            = '0;
    bus.m_address      = '0;
    bus.m_data_out     = '0;
    bus.m_read         = '0;
    bus.m_write        = '0;
    bus.m_bus_status   = '0;
    bus.cpu_address    = 24'hABCDEF;
    bus.cpu_data_out   = 8'h5A;
    bus.cpu_read       = 1'b1;
    bus.cpu_write      = 1'b0;
    bus.cpu_bus_status = 2'b01;
    bus.cpu_bus_ack    = 1'b0;
    step();
    step();
    total_cnt++; if (bus.grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", bus.grant); else pass_cnt++;
    total_cnt++; if (bus.cpu_bus_request !== 1'b0) $display("FAIL reset_cpu_req: got %b want 0", bus.cpu_bus_request); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else pass_cnt++;
    total_cnt++; if (bus.address_out !== 24'hABCDEF || bus.read !== 1'b1)
      $display("FAIL reset_cpu_passthru: got %h/%b want abcdef/1", bus.address_out, bus.read); else pass_cnt++;
    bus.cpu_bus_ack = 1'b1;
    #1;
    total_cnt++; if (bus.address_out !== 24'h0 || bus.read !== 1'b0)
      $display("FAIL reset_idle_bus: got %h/%b want 000000/0", bus.address_out, bus.read); else pass_cnt++;
    bus.cpu_bus_ack = 1'b0;
    reset           = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_master();
    bus.m_address   = {24'h0, 24'h001000};
    bus.m_read      = 2'b01;
    bus.req         = 2'b01;
    step();
    total_cnt++; if (bus.cpu_bus_request !== 1'b1) $display("FAIL single_cpu_req: got %b want 1", bus.cpu_bus_request); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else pass_cnt++;
    step();
    step();
    total_cnt++; if (bus.grant !== 2'b00) $display("FAIL single_no_early_grant: got %b want 00", bus.grant); else pass_cnt++;
    bus.cpu_bus_ack = 1'b1;
    step();
    total_cnt++; if (bus.grant !== 2'b01) $display("FAIL single_grant: got %b want 01", bus.grant); else pass_cnt++;
    total_cnt++; if (bus.address_out !== 24'h001000 || bus.read !== 1'b1)
      $display("FAIL single_bus: got %h/%b want 001000/1", bus.address_out, bus.read); else pass_cnt++;
    total_cnt++; if (bus.owner !== 2'd0) $display("FAIL single_owner: got %0d want 0", bus.owner); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (bus.grant !== 2'b01) $display("FAIL single_hold: got %b want 01", bus.grant); else pass_cnt++;
    bus.req    = 2'b00;
    bus.m_read = 2'b00;
    step();
    total_cnt++; if (bus.grant !== 2'b00 || bus.cpu_bus_request !== 1'b0)
      $display("FAIL single_release: got grant %b req %b want 00/0", bus.grant, bus.cpu_bus_request); else pass_cnt++;
    total_cnt++; if (bus.address_out !== 24'h0) $display("FAIL single_idle_bus: got %h want 000000", bus.address_out); else pass_cnt++;
    bus.cpu_address = 24'h00BEEF;
    bus.cpu_bus_ack = 1'b0;
    #1;
    total_cnt++; if (bus.address_out !== 24'h00BEEF) $display("FAIL single_cpu_back: got %h want 00beef", bus.address_out); else pass_cnt++;
    step();
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_idle: got %b want 0", bus.busy); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    bus.m_read  = 2'b11;   // strobes must be masked during the switch cycle
    bus.m_write = 2'b00;
    bus.req     = 2'b11;
    step();
    bus.cpu_bus_ack = 1'b1;
    step();
    for (int r = 0; r < 4; r++) begin
      want = ONE_N << (r % 2);
      total_cnt++; if (bus.grant !== want) $display("FAIL rr_order_%0d: got %b want %b", r, bus.grant, want); else pass_cnt++;
      if (r < 3) begin
        repeat (4) step();
        bus.req = ~want;
        step();
        total_cnt++; if (bus.grant !== 2'b00 || bus.read !== 1'b0 || bus.write !== 1'b0 || bus.cpu_bus_request !== 1'b1)
          $display("FAIL rr_switch_%0d: got grant %b rd %b wr %b req %b want 00/0/0/1",
                   r, bus.grant, bus.read, bus.write, bus.cpu_bus_request); else pass_cnt++;
        bus.req = 2'b11;
        step();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_preemption();
    do_reset();
    bus.req = 2'b11;
    step();
    bus.cpu_bus_ack = 1'b1;
    step();
    for (int c = 0; c <= 10; c++) begin
      bus.m_read = (c == 8 || c == 9) ? 2'b01 : 2'b00;
      step();
      if (c < 10) begin
        total_cnt++; if (bus.grant !== 2'b01) $display("FAIL preempt_hold_c%0d: got %b want 01", c, bus.grant); else pass_cnt++;
      end else begin
        total_cnt++; if (bus.grant !== 2'b00) $display("FAIL preempt_drop: got %b want 00", bus.grant); else pass_cnt++;
      end
    end
    bus.m_read = 2'b00;
    step();
    total_cnt++; if (bus.grant !== 2'b10) $display("FAIL preempt_next: got %b want 10", bus.grant); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_withdrawn();
    do_reset();
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    total_cnt++; if (bus.cpu_bus_request !== 1'b1 || bus.grant !== 2'b00)
      $display("FAIL withdraw_wait: got req %b grant %b want 1/00", bus.cpu_bus_request, bus.grant); else pass_cnt++;
    bus.cpu_bus_ack = 1'b1;
    step();
    total_cnt++; if (bus.grant !== 2'b00 || bus.cpu_bus_request !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL withdraw_release: got grant %b req %b busy %b want 00/0/1",
               bus.grant, bus.cpu_bus_request, bus.busy); else pass_cnt++;
    bus.req = 2'b01;   // ignored until the arbiter is back in IDLE
    step();
    total_cnt++; if (bus.grant !== 2'b00 || bus.cpu_bus_request !== 1'b0)
      $display("FAIL withdraw_ignore: got grant %b req %b want 00/0", bus.grant, bus.cpu_bus_request); else pass_cnt++;
    bus.cpu_bus_ack = 1'b0;
    step();
    total_cnt++; if (bus.busy !== 1'b0 || bus.cpu_bus_request !== 1'b0)
      $display("FAIL withdraw_idle: got busy %b req %b want 0/0", bus.busy, bus.cpu_bus_request); else pass_cnt++;
    step();
    total_cnt++; if (bus.cpu_bus_request !== 1'b1) $display("FAIL withdraw_rerequest: got %b want 1", bus.cpu_bus_request); else pass_cnt++;
    bus.req = 2'b00;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_tenure();
    do_reset();
    bus.req = 2'b10;
    step();
    bus.cpu_bus_ack = 1'b1;
    step();
    total_cnt++; if (bus.grant !== 2'b10 || bus.owner !== 2'd1)
      $display("FAIL midrst_grant: got %b/%0d want 10/1", bus.grant, bus.owner); else pass_cnt++;
    repeat (2) step();
    reset = 1'b1;
    step();
    total_cnt++; if (bus.grant !== 2'b00 || bus.cpu_bus_request !== 1'b0 || bus.busy !== 1'b0 || bus.owner !== 2'd0)
      $display("FAIL midrst_state: got grant %b req %b busy %b owner %0d want 00/0/0/0",
               bus.grant, bus.cpu_bus_request, bus.busy, bus.owner); else pass_cnt++;
    reset           = 1'b0;
    bus.cpu_bus_ack = 1'b0;
    bus.req         = 2'b11;
    step();
    bus.cpu_bus_ack = 1'b1;
    step();
    total_cnt++; if (bus.grant !== 2'b01) $display("FAIL midrst_first: got %b want 01", bus.grant); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [N-1:0]  flip;
    logic [31:0]   r1;
    logic [31:0]   r2;
    logic [63:0]   r64;
    logic [35:0]   got_bus;
    logic [35:0]   want_bus;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      flip  = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) flip = flip | (ONE_N << i);
      bus.req = bus.req ^ flip;
      r1 = $urandom();
      r2 = $urandom();
      bus.m_read       = r1[N-1:0] & r2[N-1:0];
      bus.m_write      = r1[N+7:8] & r2[N+7:8];
      bus.m_bus_status = r1[2*N+15:16];
      bus.m_data_out   = r2[8*N+15:16];
      r64 = {$urandom(), $urandom()};
      bus.m_address      = r64[24*N-1:0];
      bus.cpu_address    = r64[63:40];
      bus.cpu_data_out   = r1[31:24];
      bus.cpu_read       = r2[4];
      bus.cpu_write      = r2[5];
      bus.cpu_bus_status = r2[7:6];
      // CPU follows the request after a random delay.
      if (bus.cpu_bus_request != bus.cpu_bus_ack && $urandom_range(0, 2) == 0)
        bus.cpu_bus_ack = ~bus.cpu_bus_ack;
      step();
      total_cnt++; if (bus.grant !== exp_grant())
        $display("FAIL rand_grant@%0d: got %b want %b", cyc, bus.grant, exp_grant()); else pass_cnt++;
      total_cnt++; if (bus.cpu_bus_request !== md_cpu_req)
        $display("FAIL rand_cpu_req@%0d: got %b want %b", cyc, bus.cpu_bus_request, md_cpu_req); else pass_cnt++;
      total_cnt++; if (bus.busy !== (md_phase != M_IDLE))
        $display("FAIL rand_busy@%0d: got %b want %b", cyc, bus.busy, md_phase != M_IDLE); else pass_cnt++;
      if (md_owner >= 0) begin
        total_cnt++; if (int'(bus.owner) != md_owner_out)
          $display("FAIL rand_owner@%0d: got %0d want %0d", cyc, bus.owner, md_owner_out); else pass_cnt++;
      end
      got_bus  = {bus.address_out, bus.data_out, bus.write, bus.read, bus.bus_status};
      want_bus = exp_bus();
      total_cnt++; if (got_bus !== want_bus)
        $display("FAIL rand_bus@%0d: got %h want %h", cyc, got_bus, want_bus); else pass_cnt++;
      total_cnt++; if ($countones(bus.grant) > 1)
        $display("FAIL rand_onehot@%0d: got %b want at most one bit", cyc, bus.grant); else pass_cnt++;
      total_cnt++; if (bus.grant != '0 && !bus.cpu_bus_ack)
        $display("FAIL rand_grant_no_ack@%0d: got grant %b with ack 0 want 00", cyc, bus.grant); else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_preemption();
    test_withdrawn();
    test_reset_mid_tenure();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
